uart_tx_frame: RTL

//  UART serializer and transmit-side counterpart of the UART receiver.
//  - Accepts a parallel word on a valid strobe.
//  - Drives the frame onto TX_OUT: start(0), DATA_WIDTH data bits LSB first,

---
 rtl/uart_tx_frame_if.sv | 30 +++
 rtl/uart_tx_frame.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: parallel-side request and serial-side status of the UART
// transmitter, grouped into one bundle.
// Handshake: the source raises Data_Valid with P_DATA/PAR_EN/PAR_TYP/Prescale
// stable; the word is taken on the first rising CLK edge where Data_Valid=1
// and Busy=0. Busy acts as the inverted ready. A request seen while Busy=1 is
// dropped, not queued.
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
);
   logic [DATA_WIDTH-1:0]     P_DATA;
   logic                      Data_Valid;
   logic                      PAR_EN;
   logic                      PAR_TYP;
   logic [PRESCALE_WIDTH-1:0] Prescale;
   logic                      TX_OUT;
   logic                      Busy;

   // Data source side
   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
      input  TX_OUT, Busy
   );

   // Transmitter side
   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
      output TX_OUT, Busy
   );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART serializer. A word accepted on Data_Valid is sent as
// start(0), DATA_WIDTH data bits LSB first, optional parity, and stop(1).
// Every bit lasts Prescale CLK cycles; a Prescale of 0 is treated as 1.
// TX_OUT and Busy come straight from flops, so the pin cannot glitch.
// Build option: define UART_TX_TWO_STOP_EN to send two stop bits (the STOP
// state lasts 2*Ps cycles). The port list is the same in both builds.
module uart_tx_frame #(
   parameter int DATA_WIDTH        = 8,
   parameter int PRESCALE_WIDTH    = 6,
   parameter int BIT_COUNTER_WIDTH = 4
) (
   input  logic           CLK,
   input  logic           RST,
   uart_tx_frame_if.slave bus,
   output logic [2:0]     state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                       state;
   logic [PRESCALE_WIDTH-1:0]    cnt;
   logic [PRESCALE_WIDTH-1:0]    ps_q;
   logic [BIT_COUNTER_WIDTH-1:0] bit_idx;
   logic [DATA_WIDTH-1:0]        data_q;
   logic [DATA_WIDTH-1:0]        shift_q;
   logic                         par_en_q;
   logic                         par_typ_q;
   logic                         tx_q;
   logic                         busy_q;
`ifdef UART_TX_TWO_STOP_EN
   logic                         stop_second;
`endif

   logic bit_end;
   logic parity_bit;

   // Last cycle of the current bit; the accepted prescale is never zero.
   assign bit_end    = (cnt == (ps_q - PRESCALE_WIDTH'(1)));
   // Even parity is the XOR of the word; odd parity is its complement.
   assign parity_bit = par_typ_q ? ~^data_q : ^data_q;

   assign bus.TX_OUT = tx_q;
   assign bus.Busy   = busy_q;
   assign state_dbg  = state;

   // Frame sequencer: accepts a word, then walks start/data/parity/stop,
   // holding each bit for ps_q cycles and registering TX_OUT and Busy.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ps_q      <= '0;
         bit_idx   <= '0;
         data_q    <= '0;
         shift_q   <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop_second <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.Data_Valid) begin
                  data_q    <= bus.P_DATA;
                  shift_q   <= bus.P_DATA;
                  par_en_q  <= bus.PAR_EN;
                  par_typ_q <= bus.PAR_TYP;
                  ps_q      <= (bus.Prescale == '0) ? PRESCALE_WIDTH'(1) : bus.Prescale;
                  cnt       <= '0;
                  bit_idx   <= '0;
                  state     <= S_START;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end

            S_START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state   <= S_DATA;
               end else begin
                  cnt <= cnt + PRESCALE_WIDTH'(1);
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == BIT_COUNTER_WIDTH'(DATA_WIDTH - 1)) begin
                     bit_idx <= '0;
                     if (par_en_q) begin
                        state <= S_PARITY;
                        tx_q  <= parity_bit;
                     end else begin
                        state <= S_STOP;
                        tx_q  <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + BIT_COUNTER_WIDTH'(1);
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end else begin
                  cnt <= cnt + PRESCALE_WIDTH'(1);
               end
            end

            S_PARITY: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= S_STOP;
                  tx_q  <= 1'b1;
               end else begin
                  cnt <= cnt + PRESCALE_WIDTH'(1);
               end
            end

            S_STOP: begin
               if (bit_end) begin
                  cnt <= '0;
`ifdef UART_TX_TWO_STOP_EN
                  if (!stop_second) begin
                     stop_second <= 1'b1;
                  end else begin
                     stop_second <= 1'b0;
                     state       <= S_IDLE;
                     busy_q      <= 1'b0;
                  end
`else
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + PRESCALE_WIDTH'(1);
               end
            end

            default: begin
               state  <= S_IDLE;
               cnt    <= '0;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
